ok_btpipe_out_buffer: RTL and testbench

Responder side of host block reads on ZEM5310. Buffers a 32-bit user stream in an internal FIFO and serves the block-throttled pipe-out endpoint strobe interface (ep_read / ep_blockstrobe / ep_ready / ep_datain). ep_ready asserts only when one full block is resident, so the host never reads mid-block from an empty buffer. Sits between user datapath logic and a BTPipeOut endpoint on the okHE/okEH bus, all in the okClk domain.

---
 rtl/ok_btpipe_out_buffer.sv | 132 +++++++++++++
 tb/tb_ok_btpipe_out_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ok_btpipe_out_buffer.sv
// Pipe-out responder buffer: a 32-bit user stream is queued in a circular FIFO and drained
// by block-throttled endpoint reads. ep_ready asserts only when a whole block is resident.
module ok_btpipe_out_buffer #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  okClk,
  input  logic                  reset,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic                  ep_ready,
  output logic [31:0]           ep_datain,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  output logic [15:0]           blocks_served
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH    = PTR_W'(2 ** DEPTH_LOG2);
  localparam logic [PTR_W-1:0] BLK      = PTR_W'(BLOCK_WORDS);
  localparam logic [PTR_W-1:0] BLK_LAST = PTR_W'(BLOCK_WORDS - 1);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BLOCK = 1'b1;

  logic [31:0]      mem [0:(2**DEPTH_LOG2)-1];
  logic [31:0]      ep_datain_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] rcnt_q, rcnt_d;
  logic [0:0]       state_q, state_d;
  logic             ep_ready_q, ep_ready_d;
  logic             underflow_q, underflow_d;
  logic [15:0]      blocks_q, blocks_d;

  logic             wr_en;
  logic             rd_en;

  // Held low while reset is asserted so the user side never pushes into a clearing buffer.
  assign s_ready = ~reset & (level_q < DEPTH);
  assign wr_en   = s_valid & s_ready;
  assign rd_en   = ep_read & (level_q != '0);

  always_comb begin
    wr_ptr_d    = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
    level_d     = level_q;
    if (wr_en && !rd_en) begin
      level_d = level_q + ONE;
    end else if (rd_en && !wr_en) begin
      level_d = level_q - ONE;
    end
    underflow_d = underflow_q | (ep_read & (level_q == '0));
  end

  // Block tracking: every strobe-in-BLOCK is ignored; reads in IDLE are served but not counted.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    blocks_d = blocks_q;
    case (state_q)
      ST_IDLE: begin
        if (ep_blockstrobe) begin
          state_d = ST_BLOCK;
          rcnt_d  = '0;
        end
      end
      ST_BLOCK: begin
        if (ep_read) begin
          if (rcnt_q == BLK_LAST) begin
            state_d  = ST_IDLE;
            blocks_d = blocks_q + 16'd1;
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Requiring IDLE both now and next forces a one-cycle gap after each block.
    ep_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && (level_q >= BLK);
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rcnt_q      <= '0;
      state_q     <= ST_IDLE;
      ep_ready_q  <= 1'b0;
      underflow_q <= 1'b0;
      blocks_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rcnt_q      <= rcnt_d;
      state_q     <= state_d;
      ep_ready_q  <= ep_ready_d;
      underflow_q <= underflow_d;
      blocks_q    <= blocks_d;
    end
  end

  always_ff @(posedge okClk) begin
    if (wr_en) begin
      mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_data;
    end
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      ep_datain_q <= '0;
    end else if (rd_en) begin
      ep_datain_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  assign ep_ready      = ep_ready_q;
  assign ep_datain     = ep_datain_q;
  assign level         = level_q;
  assign underflow     = underflow_q;
  assign blocks_served = blocks_q;

endmodule

// File: tb/tb_ok_btpipe_out_buffer.sv
// Directed bench for ok_btpipe_out_buffer: fill, block reads, full, wrap, underflow, mid-block reset.
module tb_ok_btpipe_out_buffer;

  logic        okClk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        ep_read = 1'b0;
  logic        ep_blockstrobe = 1'b0;
  logic        ep_ready;
  logic [31:0] ep_datain;
  logic [10:0] level;
  logic        underflow;
  logic [15:0] blocks_served;

  int checks = 0;
  int errors = 0;

  ok_btpipe_out_buffer #(.DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut (
    .okClk          (okClk),
    .reset          (reset),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .ep_read        (ep_read),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_ready       (ep_ready),
    .ep_datain      (ep_datain),
    .level          (level),
    .underflow      (underflow),
    .blocks_served  (blocks_served)
  );

  always #5 okClk = ~okClk;

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    check("s_ready_in_reset", 32'(s_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("s_ready_after_reset", 32'(s_ready), 32'd1);
    check("ep_ready_reset", 32'(ep_ready), 32'd0);
    check("ep_datain_reset", ep_datain, 32'd0);
    check("level_reset", 32'(level), 32'd0);
    check("underflow_reset", 32'(underflow), 32'd0);
    check("blocks_reset", 32'(blocks_served), 32'd0);

    // 255 words: one short of a block
    push_n(32'd0, 255);
    check("level_255", 32'(level), 32'd255);
    check("ep_ready_255", 32'(ep_ready), 32'd0);
    push_n(32'd255, 1);
    check("ep_ready_1cyc_after_256th", 32'(ep_ready), 32'd0);
    tick();
    check("ep_ready_2cyc_after_256th", 32'(ep_ready), 32'd1);

    // One full block
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    check("ep_ready_after_strobe", 32'(ep_ready), 32'd0);
    for (int i = 0; i < 256; i++) begin
      ep_read = 1'b1;
      tick();
      check($sformatf("blk1_data_%0d", i), ep_datain, 32'(i));
      check($sformatf("blk1_ready_%0d", i), 32'(ep_ready), 32'd0);
    end
    ep_read = 1'b0;
    check("blk1_level", 32'(level), 32'd0);
    check("blk1_served", 32'(blocks_served), 32'd1);
    tick();
    check("blk1_ready_after", 32'(ep_ready), 32'd0);

    // Fill to full; extra writes must be refused
    push_n(32'hA000_0000, 1024);
    check("full_level", 32'(level), 32'd1024);
    check("full_s_ready", 32'(s_ready), 32'd0);
    push_n(32'hDEAD_BEEF, 3);
    check("full_level_after_extra", 32'(level), 32'd1024);
    ep_read = 1'b1;
    tick();
    ep_read = 1'b0;
    check("full_first_read", ep_datain, 32'hA000_0000);
    check("full_level_after_read", 32'(level), 32'd1023);
    check("full_s_ready_after_read", 32'(s_ready), 32'd1);

    // Drain outside a block down to 300 words (not counted as a block)
    for (int i = 1; i <= 723; i++) begin
      ep_read = 1'b1;
      tick();
      check($sformatf("drain_data_%0d", i), ep_datain, 32'hA000_0000 + 32'(i));
    end
    ep_read = 1'b0;
    check("drain_level", 32'(level), 32'd300);
    check("drain_served_unchanged", 32'(blocks_served), 32'd1);

    // Simultaneous write and read across the read pointer wrap
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = 32'hB000_0000 + 32'(i);
      ep_read = 1'b1;
      tick();
      check($sformatf("sim_data_%0d", i), ep_datain, 32'hA000_0000 + 32'(724 + i));
      check($sformatf("sim_level_%0d", i), 32'(level), 32'd300);
    end
    s_valid = 1'b0;
    ep_read = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ep_read = 1'b1;
      tick();
      if (i < 200) check($sformatf("wrap_old_%0d", i), ep_datain, 32'hA000_0000 + 32'(824 + i));
      else check($sformatf("wrap_new_%0d", i), ep_datain, 32'hB000_0000 + 32'(i - 200));
    end
    ep_read = 1'b0;
    check("wrap_level", 32'(level), 32'd0);

    // Underflow: read while empty
    ep_read = 1'b1;
    tick();
    ep_read = 1'b0;
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_datain_hold", ep_datain, 32'hB000_0063);
    check("uf_level", 32'(level), 32'd0);
    push_n(32'h0000_1234, 1);
    ep_read = 1'b1;
    tick();
    ep_read = 1'b0;
    check("uf_ptr_unchanged", ep_datain, 32'h0000_1234);
    check("uf_sticky", 32'(underflow), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("uf_cleared", 32'(underflow), 32'd0);
    check("reset2_blocks", 32'(blocks_served), 32'd0);
    check("reset2_datain", ep_datain, 32'd0);

    // Reset in the middle of a block
    push_n(32'hC000_0000, 256);
    tick();
    check("mid_ep_ready", 32'(ep_ready), 32'd1);
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ep_read = 1'b1;
      tick();
    end
    ep_read = 1'b0;
    check("mid_data_100", ep_datain, 32'hC000_0063);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("mid_reset_level", 32'(level), 32'd0);
    check("mid_reset_ready", 32'(ep_ready), 32'd0);
    check("mid_reset_blocks", 32'(blocks_served), 32'd0);

    // Next full block after the reset is served normally
    push_n(32'hD000_0000, 256);
    tick();
    check("post_ep_ready", 32'(ep_ready), 32'd1);
    ep_blockstrobe = 1'b1;
    tick();
    ep_blockstrobe = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ep_read = 1'b1;
      tick();
      check($sformatf("post_data_%0d", i), ep_datain, 32'hD000_0000 + 32'(i));
    end
    ep_read = 1'b0;
    check("post_served", 32'(blocks_served), 32'd1);
    check("post_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
